// File: rtl/mcbsp_controller.sv
// McBSP slave: oversamples the serial port in the a_clk domain, assembles received
// frames into dataset_read and serializes eight latched stream words back out.

module mcbsp_tx_lane #(
  parameter int DW = 32,
  parameter int WW = 32
) (
  input  logic          gclk,
  input  logic          grst_n,
  input  logic          latch,
  input  logic          tvalid,
  input  logic [DW-1:0] tdata,
  output logic [WW-1:0] word
);
  // An invalid lane at frame latch keeps retransmitting its previous word.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)               word <= '0;
    else if (latch && tvalid)  word <= WW'(tdata);
  end
endmodule

module mcbsp_controller #(
  parameter int WORDS_PER_FRAME   = 8,
  parameter int BITS_PER_WORD     = 32,
  parameter int SAXIS_TDATA_WIDTH = 32
) (
  input  logic                                        a_clk,
  input  logic                                        a_resetn,
  input  logic                                        mcbsp_clk,
  input  logic                                        mcbsp_frame_start,
  input  logic                                        mcbsp_data_rx,
  input  logic                                        mcbsp_data_nrx,
  output logic                                        mcbsp_data_clkr,
  output logic                                        mcbsp_data_tx,
  output logic                                        mcbsp_data_fsx,
  output logic                                        mcbsp_data_frm,
  output logic                                        trigger,
  output logic [WORDS_PER_FRAME*BITS_PER_WORD-1:0]    dataset_read,
  input  logic [SAXIS_TDATA_WIDTH-1:0]                S_AXIS1_tdata,
  input  logic                                        S_AXIS1_tvalid,
  input  logic [SAXIS_TDATA_WIDTH-1:0]                S_AXIS2_tdata,
  input  logic                                        S_AXIS2_tvalid,
  input  logic [SAXIS_TDATA_WIDTH-1:0]                S_AXIS3_tdata,
  input  logic                                        S_AXIS3_tvalid,
  input  logic [SAXIS_TDATA_WIDTH-1:0]                S_AXIS4_tdata,
  input  logic                                        S_AXIS4_tvalid,
  input  logic [SAXIS_TDATA_WIDTH-1:0]                S_AXIS5_tdata,
  input  logic                                        S_AXIS5_tvalid,
  input  logic [SAXIS_TDATA_WIDTH-1:0]                S_AXIS6_tdata,
  input  logic                                        S_AXIS6_tvalid,
  input  logic [SAXIS_TDATA_WIDTH-1:0]                S_AXIS7_tdata,
  input  logic                                        S_AXIS7_tvalid,
  input  logic [SAXIS_TDATA_WIDTH-1:0]                S_AXIS8_tdata,
  input  logic                                        S_AXIS8_tvalid
);
  localparam int N      = WORDS_PER_FRAME * BITS_PER_WORD;
  localparam int CW     = $clog2(N + 1);
  localparam int IW     = (N > 1) ? $clog2(N) : 1;
  localparam int STAGES = 1;
  localparam logic [CW-1:0] N_LAST = CW'(N - 1);
  localparam logic [CW-1:0] N_END  = CW'(N);

  typedef enum logic {RX_IDLE, RX_SHIFT} rx_state_e;

  logic nrx_unused;
  assign nrx_unused = mcbsp_data_nrx;

  // 2-flop synchronizers plus one extra stage on the clock for edge detection
  logic [1:0] clk_sync, fs_sync, rx_sync;
  logic       clk_q;

  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      clk_sync <= '0;
      fs_sync  <= '0;
      rx_sync  <= '0;
      clk_q    <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], mcbsp_clk};
      fs_sync  <= {fs_sync[0], mcbsp_frame_start};
      rx_sync  <= {rx_sync[0], mcbsp_data_rx};
      clk_q    <= clk_sync[1];
    end
  end

  logic clk_rise, clk_fall, frame_latch;
  assign clk_rise        = clk_sync[1] & ~clk_q;
  assign clk_fall        = ~clk_sync[1] & clk_q;
  assign frame_latch     = clk_fall & fs_sync[1];
  assign mcbsp_data_clkr = clk_sync[1];

  // Per-word transmit latches
  logic [7:0][SAXIS_TDATA_WIDTH-1:0]             s_tdata;
  logic [7:0]                                    s_tvalid;
  logic [WORDS_PER_FRAME-1:0][BITS_PER_WORD-1:0] tx_words;
  logic [N-1:0]                                  tx_frame;

  assign s_tdata  = {S_AXIS8_tdata, S_AXIS7_tdata, S_AXIS6_tdata, S_AXIS5_tdata,
                     S_AXIS4_tdata, S_AXIS3_tdata, S_AXIS2_tdata, S_AXIS1_tdata};
  assign s_tvalid = {S_AXIS8_tvalid, S_AXIS7_tvalid, S_AXIS6_tvalid, S_AXIS5_tvalid,
                     S_AXIS4_tvalid, S_AXIS3_tvalid, S_AXIS2_tvalid, S_AXIS1_tvalid};
  assign tx_frame = tx_words;

  for (genvar i = 0; i < WORDS_PER_FRAME; i++) begin : g_lane
    logic                         lane_vld;
    logic [SAXIS_TDATA_WIDTH-1:0] lane_dat;
    if (i < 8) begin : g_port
      assign lane_vld = s_tvalid[i];
      assign lane_dat = s_tdata[i];
    end else begin : g_tie
      assign lane_vld = 1'b0;
      assign lane_dat = '0;
    end
    mcbsp_tx_lane #(.DW(SAXIS_TDATA_WIDTH), .WW(BITS_PER_WORD)) u_lane (
      .gclk   (a_clk),
      .grst_n (a_resetn),
      .latch  (frame_latch),
      .tvalid (lane_vld),
      .tdata  (lane_dat),
      .word   (tx_words[i])
    );
  end

  // Receive: only frames opened by frame_start are collected; padding leaves it idle
  rx_state_e         rx_st, rx_nxt;
  logic [CW-1:0]     rx_cnt;
  logic [N-1:0]      shift_reg;
  logic              rx_store, frame_done;
  logic [STAGES:0]   vld_pipe;

  always_comb begin
    rx_nxt     = rx_st;
    rx_store   = 1'b0;
    frame_done = 1'b0;
    if (frame_latch) begin
      rx_nxt = RX_SHIFT;
    end else if (clk_fall && rx_st == RX_SHIFT) begin
      rx_store = 1'b1;
      if (rx_cnt == N_LAST) begin
        frame_done = 1'b1;
        rx_nxt     = RX_IDLE;
      end
    end
  end

  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      rx_st        <= RX_IDLE;
      rx_cnt       <= '0;
      shift_reg    <= '0;
      vld_pipe     <= '0;
      dataset_read <= '0;
    end else begin
      rx_st    <= rx_nxt;
      vld_pipe <= {vld_pipe[STAGES-1:0], frame_done};
      if (frame_latch) begin
        shift_reg[0] <= rx_sync[1];
        rx_cnt       <= CW'(1);
      end else if (rx_store) begin
        shift_reg[rx_cnt[IW-1:0]] <= rx_sync[1];
        rx_cnt                    <= rx_cnt + CW'(1);
      end
      if (vld_pipe[0]) dataset_read <= shift_reg;
    end
  end

  assign trigger = vld_pipe[STAGES];

  // Transmit: bit k goes out on the k-th rising edge after the latching fall
  logic [CW-1:0] tx_cnt;
  logic          tx_armed;

  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      tx_cnt         <= '0;
      tx_armed       <= 1'b0;
      mcbsp_data_tx  <= 1'b0;
      mcbsp_data_fsx <= 1'b0;
      mcbsp_data_frm <= 1'b0;
    end else if (frame_latch) begin
      tx_cnt   <= '0;
      tx_armed <= 1'b1;
    end else if (clk_rise) begin
      if (tx_armed && tx_cnt < N_END) begin
        mcbsp_data_tx  <= tx_frame[tx_cnt[IW-1:0]];
        mcbsp_data_fsx <= (tx_cnt == '0);
        mcbsp_data_frm <= 1'b1;
        tx_cnt         <= tx_cnt + CW'(1);
      end else begin
        mcbsp_data_tx  <= 1'b0;
        mcbsp_data_fsx <= 1'b0;
        mcbsp_data_frm <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mcbsp_controller.sv
// Directed-sequence bench for mcbsp_controller with randomized data; a bit-stream
// model of the McBSP frame protocol provides every expected value.

module tb_mcbsp_controller;
  localparam int N    = 256;
  localparam int PAD  = 10;
  localparam int HALF = 12;
  localparam int MAXW = 288;

  logic a_clk = 1'b0;
  logic a_resetn = 1'b0;
  logic mcbsp_clk = 1'b0;
  logic fs_drv = 1'b0;
  logic rx_drv = 1'b0;
  logic loop_en = 1'b0;
  logic rx_line;
  logic nrx = 1'b0;
  logic mcbsp_data_clkr, mcbsp_data_tx, mcbsp_data_fsx, mcbsp_data_frm, trigger;
  logic [N-1:0] dataset_read;
  logic [31:0] tdata [8];
  logic [7:0]  tvalid = '0;

  assign rx_line = loop_en ? mcbsp_data_tx : rx_drv;

  always #5 a_clk = ~a_clk;

  mcbsp_controller dut (
    .a_clk(a_clk), .a_resetn(a_resetn),
    .mcbsp_clk(mcbsp_clk), .mcbsp_frame_start(fs_drv),
    .mcbsp_data_rx(rx_line), .mcbsp_data_nrx(nrx),
    .mcbsp_data_clkr(mcbsp_data_clkr), .mcbsp_data_tx(mcbsp_data_tx),
    .mcbsp_data_fsx(mcbsp_data_fsx), .mcbsp_data_frm(mcbsp_data_frm),
    .trigger(trigger), .dataset_read(dataset_read),
    .S_AXIS1_tdata(tdata[0]), .S_AXIS1_tvalid(tvalid[0]),
    .S_AXIS2_tdata(tdata[1]), .S_AXIS2_tvalid(tvalid[1]),
    .S_AXIS3_tdata(tdata[2]), .S_AXIS3_tvalid(tvalid[2]),
    .S_AXIS4_tdata(tdata[3]), .S_AXIS4_tvalid(tvalid[3]),
    .S_AXIS5_tdata(tdata[4]), .S_AXIS5_tvalid(tvalid[4]),
    .S_AXIS6_tdata(tdata[5]), .S_AXIS6_tvalid(tvalid[5]),
    .S_AXIS7_tdata(tdata[6]), .S_AXIS7_tvalid(tvalid[6]),
    .S_AXIS8_tdata(tdata[7]), .S_AXIS8_tvalid(tvalid[7])
  );

  int trig_cnt = 0;
  always @(negedge a_clk) if (trigger === 1'b1) trig_cnt <= trig_cnt + 1;

  int n_checks = 0;
  int n_pass   = 0;

  // Protocol model state
  logic [N-1:0]    m_words   = '0;
  logic [N-1:0]    m_dataset = '0;
  int              m_pos     = N;
  bit              m_collect = 1'b0;
  int              m_trigs   = 0;
  logic            m_q[$];
  logic [MAXW-1:0] last_otx;

  task automatic chk(input string tag, input logic [MAXW-1:0] obs, input logic [MAXW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_words   = '0;
    m_dataset = '0;
    m_pos     = N;
    m_collect = 1'b0;
    m_q.delete();
  endtask

  function automatic logic [MAXW-1:0] rand_vec();
    logic [MAXW-1:0] r;
    for (int i = 0; i < MAXW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // One bit window per iteration: master rising edge, hold, falling edge, hold.
  task automatic run_windows(input string tag, input logic [MAXW-1:0] fs_v,
                             input logic [MAXW-1:0] rx_v, input int nwin);
    logic [MAXW-1:0] etx, efsx, efrm, otx, ofsx, ofrm;
    logic clk_ok, rxb;
    etx = '0; efsx = '0; efrm = '0; otx = '0; ofsx = '0; ofrm = '0;
    clk_ok = 1'b1;
    for (int w = 0; w < nwin; w++) begin
      mcbsp_clk = 1'b1;
      fs_drv    = fs_v[w];
      rx_drv    = rx_v[w];
      if (m_pos < N) begin
        etx[w]  = m_words[m_pos];
        efsx[w] = (m_pos == 0);
        efrm[w] = 1'b1;
        m_pos++;
      end
      repeat (HALF) @(negedge a_clk);
      otx[w]  = mcbsp_data_tx;
      ofsx[w] = mcbsp_data_fsx;
      ofrm[w] = mcbsp_data_frm;
      if (mcbsp_data_clkr !== 1'b1) clk_ok = 1'b0;
      mcbsp_clk = 1'b0;
      rxb = loop_en ? etx[w] : rx_v[w];
      if (fs_v[w]) begin
        m_q.delete();
        m_q.push_back(rxb);
        m_collect = 1'b1;
        for (int i = 0; i < 8; i++) if (tvalid[i]) m_words[i*32 +: 32] = tdata[i];
        m_pos = 0;
      end else if (m_collect) begin
        m_q.push_back(rxb);
        if (m_q.size() == N) begin
          for (int i = 0; i < N; i++) m_dataset[i] = m_q[i];
          m_trigs++;
          m_collect = 1'b0;
        end
      end
      repeat (HALF) @(negedge a_clk);
      if (mcbsp_data_clkr !== 1'b0) clk_ok = 1'b0;
    end
    last_otx = otx;
    chk({tag, "_dataset"}, MAXW'(dataset_read), MAXW'(m_dataset));
    chk({tag, "_trigs"},   MAXW'(trig_cnt),     MAXW'(m_trigs));
    chk({tag, "_tx"},      otx,  etx);
    chk({tag, "_fsx"},     ofsx, efsx);
    chk({tag, "_frm"},     ofrm, efrm);
    chk({tag, "_clkr"},    MAXW'(clk_ok), MAXW'(1'b1));
  endtask

  initial begin
    logic [MAXW-1:0] fs0, rx13;
    logic [N-1:0]    lw;
    fs0  = MAXW'(1);
    rx13 = MAXW'(13);
    for (int i = 0; i < 8; i++) tdata[i] = '0;

    // Reset state
    repeat (3) @(negedge a_clk);
    chk("rst_dataset", MAXW'(dataset_read), '0);
    chk("rst_trigger", MAXW'(trigger), '0);
    chk("rst_tx",      MAXW'(mcbsp_data_tx), '0);
    chk("rst_fsx",     MAXW'(mcbsp_data_fsx), '0);
    chk("rst_frm",     MAXW'(mcbsp_data_frm), '0);
    chk("rst_clkr",    MAXW'(mcbsp_data_clkr), '0);
    a_resetn = 1'b1;
    repeat (3) @(negedge a_clk);

    // Clock return lags mcbsp_clk by two a_clk cycles
    mcbsp_clk = 1'b1;
    @(negedge a_clk);
    chk("clkr_lag1", MAXW'(mcbsp_data_clkr), MAXW'(1'b0));
    @(negedge a_clk);
    chk("clkr_lag2", MAXW'(mcbsp_data_clkr), MAXW'(1'b1));
    repeat (HALF) @(negedge a_clk);
    mcbsp_clk = 1'b0;
    repeat (HALF) @(negedge a_clk);

    // Word0 = 13 frames, one trigger each
    run_windows("w13a", fs0, rx13, N + PAD);
    chk("w13_value", MAXW'(dataset_read), MAXW'(13));
    run_windows("w13b", fs0, rx13, N + PAD);
    chk("w13_two_trigs", MAXW'(trig_cnt), MAXW'(2));

    // Fixed transmit words
    tdata[0] = 13;  tdata[1] = 45;  tdata[2] = 77;  tdata[3] = 109;
    tdata[4] = 141; tdata[5] = 269; tdata[6] = 525; tdata[7] = 1037;
    tvalid = 8'hFF;
    run_windows("txfix", fs0, rand_vec(), N + PAD);
    chk("txfix_word0", MAXW'(last_otx[32:1]),    MAXW'(13));
    chk("txfix_word7", MAXW'(last_otx[256:225]), MAXW'(1037));

    // S_AXIS3 invalid: word 2 retransmits 77
    for (int i = 0; i < 8; i++) tdata[i] = $urandom;
    tvalid = 8'hFB;
    run_windows("hold3", fs0, rand_vec(), N + PAD);
    chk("hold3_word2", MAXW'(last_otx[96:65]), MAXW'(77));

    // Random words and valids
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 8; i++) tdata[i] = $urandom;
      tvalid = 8'($urandom);
      run_windows("rand", fs0, rand_vec(), N + PAD);
    end

    // Loopback: the echo arrives one bit window after it leaves
    for (int i = 0; i < 8; i++) tdata[i] = $urandom;
    tvalid = 8'hFF;
    for (int i = 0; i < 8; i++) lw[i*32 +: 32] = tdata[i];
    loop_en = 1'b1;
    run_windows("loop", fs0, '0, N + PAD);
    loop_en = 1'b0;
    chk("loop_words", MAXW'(dataset_read[N-1:1]), MAXW'(lw[N-2:0]));

    // Frame restarted at bit 100: aborted part must not trigger
    run_windows("abort_part", fs0, rand_vec(), 100);
    run_windows("abort_full", fs0, rand_vec(), N + PAD);

    // Reset pulse mid-frame
    tvalid = 8'h00;
    run_windows("pre_rst", fs0, rand_vec(), 50);
    mcbsp_clk = 1'b1;
    fs_drv    = 1'b0;
    rx_drv    = 1'b0;
    repeat (6) @(negedge a_clk);
    #2 a_resetn = 1'b0;
    #1;
    chk("midrst_dataset", MAXW'(dataset_read), '0);
    chk("midrst_trigger", MAXW'(trigger), '0);
    chk("midrst_tx",      MAXW'(mcbsp_data_tx), '0);
    chk("midrst_fsx",     MAXW'(mcbsp_data_fsx), '0);
    chk("midrst_frm",     MAXW'(mcbsp_data_frm), '0);
    chk("midrst_clkr",    MAXW'(mcbsp_data_clkr), '0);
    model_reset();
    repeat (5) @(negedge a_clk);
    a_resetn = 1'b1;
    repeat (6) @(negedge a_clk);
    mcbsp_clk = 1'b0;
    repeat (HALF) @(negedge a_clk);
    run_windows("post_rst_tail", '0, rand_vec(), N - 51);
    run_windows("post_rst_frame", fs0, rand_vec(), N + PAD);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
